// File: rtl/mem_access_unit.sv
// Byte-addressed data memory with a fixed-latency IDLE/WAIT/RESP access handshake.
// Supports byte/half/word loads and stores, misalignment flagging and a debug read port.
module mem_access_unit #(
  parameter int NB           = 32,
  parameter int DEPTH        = 64,
  parameter int WAIT_STATES  = 2,
  parameter int NB_SIZE_TYPE = 3
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_step,
  input  logic                    i_mem_read,
  input  logic                    i_mem_write,
  input  logic [NB-1:0]           i_alu_address_result,
  input  logic [NB-1:0]           i_data_b_to_write,
  input  logic [NB_SIZE_TYPE-1:0] i_word_size,
  input  logic                    i_signed,
  input  logic [NB-1:0]           i_debug_address,
  output logic                    o_ready,
  output logic                    o_valid,
  output logic                    o_misaligned,
  output logic [NB-1:0]           o_data_memory,
  output logic [NB-1:0]           o_data_debug_memory
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LANES = NB / 8;

  localparam logic [NB_SIZE_TYPE-1:0] BYTE_WORD     = NB_SIZE_TYPE'(0);
  localparam logic [NB_SIZE_TYPE-1:0] HALF_WORD     = NB_SIZE_TYPE'(1);
  localparam logic [NB_SIZE_TYPE-1:0] COMPLETE_WORD = NB_SIZE_TYPE'(2);

  localparam logic [3:0] LAST_WAIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, next_state;
  logic [3:0]              wait_cnt;
  logic [AW+1:0]           addr_q;
  logic [NB-1:0]           data_q;
  logic [NB_SIZE_TYPE-1:0] size_q;
  logic                    signed_q;
  logic                    write_q;
  logic [NB-1:0]           mem [DEPTH];
  logic [NB-1:0]           data_out;

  logic                    accept, enter_resp;
  logic [AW+1:0]           cur_addr;
  logic [NB-1:0]           cur_data;
  logic [NB_SIZE_TYPE-1:0] cur_size;
  logic                    cur_signed, cur_write;
  logic [AW-1:0]           idx;
  logic [1:0]              lane;
  logic                    is_byte, is_half, is_word, misaligned;
  logic [NB-1:0]           rd_word, load_val, wr_word;
  logic [7:0]              rd_byte;
  logic [15:0]             rd_half;
  logic [LANES-1:0]        lane_en;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_alu_address_result[NB-1:AW+2],
                              i_debug_address[NB-1:AW+2], i_debug_address[1:0]};

  // With zero wait states RESP is entered on the accept edge itself, so the
  // access fields come straight from the ports while still in IDLE.
  always_comb begin
    if (state == IDLE) begin
      cur_addr   = i_alu_address_result[AW+1:0];
      cur_data   = i_data_b_to_write;
      cur_size   = i_word_size;
      cur_signed = i_signed;
      cur_write  = i_mem_write;
    end else begin
      cur_addr   = addr_q;
      cur_data   = data_q;
      cur_size   = size_q;
      cur_signed = signed_q;
      cur_write  = write_q;
    end
  end

  assign idx  = cur_addr[AW+1:2];
  assign lane = cur_addr[1:0];

  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    case (cur_size)
      BYTE_WORD:     is_byte = 1'b1;
      HALF_WORD:     is_half = 1'b1;
      COMPLETE_WORD: is_word = 1'b1;
      default:       is_word = 1'b1;
    endcase
  end

  assign misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));

  assign rd_word = mem[idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_val = rd_word;
    wr_word  = cur_data;
    lane_en  = '1;
    if (is_byte) begin
      load_val = cur_signed ? {{(NB-8){rd_byte[7]}}, rd_byte} : {{(NB-8){1'b0}}, rd_byte};
      wr_word  = {LANES{cur_data[7:0]}};
      lane_en  = LANES'(1) << lane;
    end else if (is_half) begin
      load_val = cur_signed ? {{(NB-16){rd_half[15]}}, rd_half} : {{(NB-16){1'b0}}, rd_half};
      wr_word  = {(NB/16){cur_data[15:0]}};
      lane_en  = LANES'(3) << {lane[1], 1'b0};
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (i_step && (i_mem_read || i_mem_write)) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            next_state = WAIT;
          end else begin
            next_state = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (i_step && (wait_cnt == LAST_WAIT)) begin
          next_state = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (i_step) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      data_out <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        addr_q   <= cur_addr;
        data_q   <= cur_data;
        size_q   <= cur_size;
        signed_q <= cur_signed;
        write_q  <= cur_write;
        wait_cnt <= '0;
      end else if (state == WAIT && i_step) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      // Misaligned accesses complete normally but touch neither the array nor the load result.
      if (enter_resp && !misaligned) begin
        if (cur_write) begin
          for (int l = 0; l < LANES; l++) begin
            if (lane_en[l]) mem[idx][l*8 +: 8] <= wr_word[l*8 +: 8];
          end
        end else begin
          data_out <= load_val;
        end
      end
    end
  end

  assign o_ready             = (state == IDLE);
  assign o_valid             = (state == RESP);
  assign o_misaligned        = (state == RESP) && misaligned;
  assign o_data_memory       = data_out;
  assign o_data_debug_memory = mem[i_debug_address[AW+1:2]];

endmodule
